// File: rtl/cpu_ctrl_fsm.sv
// cpu_ctrl_fsm: fetch/decode/execute sequencer for the 8-bit accumulator CPU.
// Three cycles per instruction. Strobes fire only in EXEC. HALT is left only
// through reset.
module cpu_ctrl_fsm #(
  parameter logic [7:0] RESET_PC   = 8'h00,
  parameter bit         AUTO_START = 1'b0
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       start,
  input  logic [7:0] instr,
  output logic [7:0] pc,
  output logic       acc_we,
  output logic [1:0] acc_sel,
  output logic       alu_op,
  output logic       reg_we,
  output logic [3:0] reg_addr,
  output logic [3:0] imm,
  output logic       halted,
  output logic       illegal
);

  localparam logic [2:0] S_IDLE   = 3'd0;
  localparam logic [2:0] S_FETCH  = 3'd1;
  localparam logic [2:0] S_DECODE = 3'd2;
  localparam logic [2:0] S_EXEC   = 3'd3;
  localparam logic [2:0] S_HALT   = 3'd4;

  localparam logic [7:0] HALT_INSTR = 8'hF0;

  logic [2:0] r_state;
  logic [2:0] w_next_state;
  logic [7:0] r_pc;
  logic [7:0] r_ir;
  logic       r_illegal;

  logic [3:0] w_opcode;
  logic [3:0] w_operand;
  logic       w_in_decode_exec;
  logic       w_in_exec;

  logic       w_dec_acc_we;
  logic       w_dec_reg_we;
  logic [1:0] w_dec_acc_sel;
  logic       w_dec_alu_op;
  logic       w_dec_illegal;

  assign w_opcode         = r_ir[7:4];
  assign w_operand        = r_ir[3:0];
  assign w_in_exec        = (r_state == S_EXEC);
  assign w_in_decode_exec = (r_state == S_DECODE) || w_in_exec;

  // Instruction decode; the HALT byte and NOP decode to no strobes.
  always_comb begin
    w_dec_acc_we  = 1'b0;
    w_dec_reg_we  = 1'b0;
    w_dec_acc_sel = 2'd0;
    w_dec_alu_op  = 1'b0;
    w_dec_illegal = 1'b0;
    case (w_opcode)
      4'h0: ;
      4'h1: begin
        w_dec_acc_we  = 1'b1;
        w_dec_acc_sel = 2'd1;
      end
      4'h2: begin
        w_dec_acc_we  = 1'b1;
        w_dec_acc_sel = 2'd1;
        w_dec_alu_op  = 1'b1;
      end
      4'h8: begin
        w_dec_acc_we  = 1'b1;
        w_dec_acc_sel = 2'd2;
      end
      4'h9: w_dec_reg_we = 1'b1;
      4'hA: begin
        w_dec_acc_we  = 1'b1;
        w_dec_acc_sel = 2'd0;
      end
      4'hF: w_dec_illegal = (w_operand != 4'h0);
      default: w_dec_illegal = 1'b1;
    endcase
  end

  // Next-state sequencing: IDLE -> FETCH -> DECODE -> EXEC -> FETCH/HALT.
  always_comb begin
    w_next_state = r_state;
    case (r_state)
      S_IDLE:   if (start || AUTO_START) w_next_state = S_FETCH;
      S_FETCH:  w_next_state = S_DECODE;
      S_DECODE: w_next_state = S_EXEC;
      S_EXEC:   w_next_state = (r_ir == HALT_INSTR) ? S_HALT : S_FETCH;
      S_HALT:   w_next_state = S_HALT;
      default:  w_next_state = S_IDLE;
    endcase
  end

  // State register.
  always_ff @(posedge clk) begin
    if (!rst_n) r_state <= S_IDLE;
    else        r_state <= w_next_state;
  end

  // Fetch: latch the ROM byte and advance pc (wraps naturally at 8 bits).
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_pc <= RESET_PC;
      r_ir <= 8'h00;
    end else if (r_state == S_FETCH) begin
      r_pc <= r_pc + 8'd1;
      r_ir <= instr;
    end
  end

  // Sticky illegal-opcode flag, cleared only by reset.
  always_ff @(posedge clk) begin
    if (!rst_n)                          r_illegal <= 1'b0;
    else if (w_in_exec && w_dec_illegal) r_illegal <= 1'b1;
  end

  // Operand fields and selects are held from DECODE through EXEC; strobes
  // are gated to EXEC. illegal shows in the offending EXEC cycle itself.
  assign pc       = r_pc;
  assign acc_we   = w_in_exec & w_dec_acc_we;
  assign reg_we   = w_in_exec & w_dec_reg_we;
  assign acc_sel  = w_in_decode_exec ? w_dec_acc_sel : 2'd0;
  assign alu_op   = w_in_decode_exec ? w_dec_alu_op  : 1'b0;
  assign reg_addr = w_in_decode_exec ? w_operand     : 4'd0;
  assign imm      = w_in_decode_exec ? w_operand     : 4'd0;
  assign halted   = (r_state == S_HALT);
  assign illegal  = r_illegal | (w_in_exec & w_dec_illegal);

endmodule
